// File: rtl/bios_loader.sv
// Copies WORDS 32-bit words from the BIOS ROM to RAM and keeps a running checksum of them.
// First write 2 cycles after start, one word per cycle; ram_ready_i low stalls the copy in place.
package bios_loader_pkg;
  typedef logic [31:0] word_t;
endpackage

module bios_loader
  import bios_loader_pkg::*;
#(
  parameter word_t SRC_BASE  = 32'h0000_0000,
  parameter word_t DEST_BASE = 32'h8000_0000,
  parameter int    WORDS     = 1024
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output word_t      rom_addr_o,
  input  word_t      rom_data_i,
  output word_t      ram_addr_o,
  output word_t      ram_data_o,
  output logic [3:0] ram_we_o,
  input  logic       ram_ready_i,
  output word_t      checksum_o
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, PRIME, COPY, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  word_t            idx_off;
  logic             accept;

  assign idx_off    = word_t'(idx) << 2;
  assign accept     = (state == COPY) && ram_ready_i;
  assign ram_we_o   = (state == COPY) ? 4'hF : 4'h0;
  assign ram_addr_o = DEST_BASE + idx_off;
  assign ram_data_o = rom_data_i;

  // Fetch one word ahead on acceptance so rom_data_i always holds word idx.
  always_comb begin
    rom_addr_o = SRC_BASE;
    if (state == COPY)
      rom_addr_o = SRC_BASE + idx_off + (accept ? 32'd4 : 32'd0);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      idx        <= '0;
      checksum_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state      <= PRIME;
            idx        <= '0;
            checksum_o <= '0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
          end
        end
        PRIME: state <= COPY;
        COPY: begin
          if (ram_ready_i) begin
            checksum_o <= checksum_o + rom_data_i;
            if (idx == LAST_IDX) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
